// File: rtl/vfpu_seq.sv
// vfpu_seq: operand sequencer and result collector for the VFPU datapath.
// Joins the A/B operand streams into VFPU issue beats and limits in-flight
// work with credits. Buffers results in a show-ahead FIFO and returns them
// in issue order.
// Optional feature: define VFPU_SEQ_FLAG_ACCUM_EN to accumulate sticky VFPU
// exception flags on flags_o. Otherwise flags_o is tied to 0.
module vfpu_seq #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned FLAGS_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [LEN_WIDTH-1:0]   len_i,
  output logic                   busy_o,
  output logic                   done_o,
  input  logic                   a_valid_i,
  output logic                   a_ready_o,
  input  logic [DATA_WIDTH-1:0]  a_data_i,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  input  logic [DATA_WIDTH-1:0]  b_data_i,
  output logic [DATA_WIDTH-1:0]  vfpu_operand_a_o,
  output logic [DATA_WIDTH-1:0]  vfpu_operand_b_o,
  output logic                   vfpu_valid_o,
  input  logic [DATA_WIDTH-1:0]  vfpu_result_i,
  input  logic [FLAGS_WIDTH-1:0] vfpu_flags_i,
  input  logic                   vfpu_done_i,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [DATA_WIDTH-1:0]  r_data_o,
  output logic [FLAGS_WIDTH-1:0] flags_o,
  output logic                   err_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e                 state_q, state_d;
  logic                   done_q, done_d;
  logic [LEN_WIDTH-1:0]   len_q, issued_q, pushed_q, popped_q;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wptr_q, rptr_q;
  logic [AW:0]            cnt_q;
  logic [DATA_WIDTH-1:0]  opa_q, opb_q;
  logic                   vvalid_q;
  logic                   err_q;

  logic                   start_acc, full, empty, pop, push_req, push, ovf;
  logic                   credit, issue;
  logic [LEN_WIDTH-1:0]   outstanding;

  assign start_acc   = (state_q == S_IDLE) && start_i;
  assign full        = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty       = (cnt_q == '0);
  assign pop         = !empty && r_ready_i;
  assign push_req    = (state_q == S_RUN) && vfpu_done_i;
  // A pop in the same cycle frees the head slot, so a push at full still lands.
  assign push        = push_req && (!full || pop);
  assign ovf         = push_req && full && !pop;
  assign outstanding = issued_q - popped_q;
  assign credit      = (outstanding < LEN_WIDTH'(FIFO_DEPTH));
  assign issue       = (state_q == S_RUN) && a_valid_i && b_valid_i && credit
                       && (issued_q < len_q);

  assign a_ready_o        = issue;
  assign b_ready_o        = issue;
  assign busy_o           = (state_q == S_RUN);
  assign done_o           = done_q;
  assign vfpu_operand_a_o = opa_q;
  assign vfpu_operand_b_o = opb_q;
  assign vfpu_valid_o     = vvalid_q;
  assign r_valid_o        = !empty;
  assign r_data_o         = mem_q[rptr_q];
  assign err_o            = err_q;

  // Next-state and completion pulse; the job ends on the cycle of its last pop.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i == '0) done_d = 1'b1;
          else             state_d = S_RUN;
        end
      end
      S_RUN: begin
        if ((popped_q + LEN_WIDTH'(pop)) == len_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, job counters, issue register and error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      len_q    <= '0;
      issued_q <= '0;
      pushed_q <= '0;
      popped_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      vvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      vvalid_q <= issue;
      if (issue) begin
        opa_q <= a_data_i;
        opb_q <= b_data_i;
      end
      if (start_acc) begin
        len_q    <= len_i;
        issued_q <= '0;
        pushed_q <= '0;
        popped_q <= '0;
        err_q    <= 1'b0;
      end else begin
        if (issue) issued_q <= issued_q + 1'b1;
        if (push)  pushed_q <= pushed_q + 1'b1;
        if (pop)   popped_q <= popped_q + 1'b1;
        if (ovf)   err_q    <= 1'b1;
      end
    end
  end

  // Result FIFO pointers and occupancy; a start flushes it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (start_acc) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Result FIFO storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= vfpu_result_i;
    end
  end

`ifdef VFPU_SEQ_FLAG_ACCUM_EN
  logic [FLAGS_WIDTH-1:0] flags_q;

  // Sticky OR of the flags of every accepted result in the current job.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          flags_q <= '0;
    else if (start_acc) flags_q <= '0;
    else if (push)      flags_q <= flags_q | vfpu_flags_i;
  end

  assign flags_o = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^vfpu_flags_i;
  assign flags_o      = '0;
`endif

endmodule
